// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline control unit: opcodes, control bundle
// layout, immediate/ALU/result/forwarding codes and the bubble constant.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       alu_src_pc;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic [2:0] imm_sel;
        logic       valid;
    } ctrl_t;

    localparam int CTRL_W         = $bits(ctrl_t);
    localparam int CTRL_VALID_LSB = 0;
    localparam int CTRL_IMM_LSB   = 1;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_JUMP_BIT  = 6;
    localparam int CTRL_BR_BIT    = 7;
    localparam int CTRL_RES_LSB   = 8;
    localparam int CTRL_MRD_BIT   = 10;
    localparam int CTRL_MWR_BIT   = 11;
    localparam int CTRL_SRCPC_BIT = 12;
    localparam int CTRL_SRC_BIT   = 13;
    localparam int CTRL_RW_BIT    = 14;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/rv_pipe_ctrl_if.sv
// ID-side request and per-stage control outputs of the pipeline control unit.
interface rv_pipe_ctrl_if
    import rv_ctrl_pkg::*;
#(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [31:0]     id_instr;
    logic            hold;
    logic            ex_redirect;
    logic            stall_if_id;
    logic            flush_if_id;
    ctrl_t           ex_ctrl;
    logic [RA_W-1:0] ex_rd;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic            mem_reg_write;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic [1:0]      mem_result_src;
    logic [RA_W-1:0] mem_rd;
    logic            wb_reg_write;
    logic [1:0]      wb_result_src;
    logic [RA_W-1:0] wb_rd;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic            illegal;

    modport master (
        output id_valid, id_instr, hold, ex_redirect,
        input  stall_if_id, flush_if_id, ex_ctrl, ex_rd, ex_rs1, ex_rs2,
        input  mem_reg_write, mem_mem_read, mem_mem_write, mem_result_src, mem_rd,
        input  wb_reg_write, wb_result_src, wb_rd, fwd_a, fwd_b, illegal
    );

    modport slave (
        input  id_valid, id_instr, hold, ex_redirect,
        output stall_if_id, flush_if_id, ex_ctrl, ex_rd, ex_rs1, ex_rs2,
        output mem_reg_write, mem_mem_read, mem_mem_write, mem_result_src, mem_rd,
        output wb_reg_write, wb_result_src, wb_rd, fwd_a, fwd_b, illegal
    );
endinterface

// File: rtl/rv_decode.sv
// Pure combinational RV32I opcode decoder: control bundle plus register-use flags.
module rv_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       uses_rs1,
    output logic       uses_rs2
);
    always_comb begin
        ctrl     = BUBBLE;
        illegal  = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
                uses_rs2       = 1'b1;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_FUNC;
                ctrl.imm_sel   = IMM_I;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_sel    = IMM_I;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.imm_sel   = IMM_S;
                uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.alu_src    = 1'b1;
                ctrl.alu_src_pc = 1'b1;
                ctrl.branch     = 1'b1;
                ctrl.alu_op     = ALUOP_BR;
                ctrl.imm_sel    = IMM_B;
                uses_rs2        = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_src_pc = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_sel    = IMM_J;
                uses_rs1        = 1'b0;
            end
            OP_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_sel    = IMM_I;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_PASSB;
                ctrl.imm_sel   = IMM_U;
                uses_rs1       = 1'b0;
            end
            OP_AUIPC: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_src_pc = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.imm_sel    = IMM_U;
                uses_rs1        = 1'b0;
            end
            default: begin
                illegal  = 1'b1;
                uses_rs1 = 1'b0;
            end
        endcase
        ctrl.valid = !illegal;
    end
endmodule

// File: rtl/rv_pipe_ctrl.sv
// Pipelined control for the 5-stage RV32I core: ID decode, ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, redirect flush and EX forwarding selects.
module rv_pipe_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int RA_W           = 5,
    parameter bit LOAD_USE_STALL = 1'b1,
    parameter bit FWD_EN         = 1'b1
)(
    input  logic           clk,
    input  logic           rst_n,
    rv_pipe_ctrl_if.slave  bus
);
    ctrl_t           dec_ctrl;
    logic            dec_illegal, dec_rs1, dec_rs2;
    logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
    logic            id_live, load_use;
    logic            unused_instr_bits;

    ctrl_t           ex_ctrl_q;
    logic [RA_W-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic            mem_rw_q, mem_mrd_q, mem_mwr_q;
    logic [1:0]      mem_res_q;
    logic [RA_W-1:0] mem_rd_q;
    logic            wb_rw_q;
    logic [1:0]      wb_res_q;
    logic [RA_W-1:0] wb_rd_q;
    logic            illegal_q;
    logic [1:0]      fwd_a_c, fwd_b_c;

    rv_decode u_decode (
        .opcode   (bus.id_instr[6:0]),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .uses_rs1 (dec_rs1),
        .uses_rs2 (dec_rs2)
    );

    assign id_rd  = bus.id_instr[7  +: RA_W];
    assign id_rs1 = bus.id_instr[15 +: RA_W];
    assign id_rs2 = bus.id_instr[20 +: RA_W];
    assign unused_instr_bits = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

    assign id_live = bus.id_valid && !dec_illegal;

    // A bubble already sits in EX after the stall cycle, so each hazard stalls once.
    assign load_use = LOAD_USE_STALL && ex_ctrl_q.mem_read && (ex_rd_q != '0) && bus.id_valid &&
                      ((dec_rs1 && ex_rd_q == id_rs1) || (dec_rs2 && ex_rd_q == id_rs2));

    assign bus.stall_if_id = bus.hold || (!bus.ex_redirect && load_use);
    assign bus.flush_if_id = !bus.hold && bus.ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q <= BUBBLE;
            ex_rd_q   <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            mem_rw_q  <= 1'b0;
            mem_mrd_q <= 1'b0;
            mem_mwr_q <= 1'b0;
            mem_res_q <= '0;
            mem_rd_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_res_q  <= '0;
            wb_rd_q   <= '0;
            illegal_q <= 1'b0;
        end else if (!bus.hold) begin
            mem_rw_q  <= ex_ctrl_q.reg_write;
            mem_mrd_q <= ex_ctrl_q.mem_read;
            mem_mwr_q <= ex_ctrl_q.mem_write;
            mem_res_q <= ex_ctrl_q.result_src;
            mem_rd_q  <= ex_rd_q;
            wb_rw_q   <= mem_rw_q;
            wb_res_q  <= mem_res_q;
            wb_rd_q   <= mem_rd_q;
            // Wrong-path instructions are squashed before they can flag illegal.
            illegal_q <= bus.id_valid && dec_illegal && !bus.ex_redirect;
            if (bus.ex_redirect || load_use || !id_live) begin
                ex_ctrl_q <= BUBBLE;
                ex_rd_q   <= '0;
                ex_rs1_q  <= '0;
                ex_rs2_q  <= '0;
            end else begin
                // Unused register fields are zeroed so they never raise a false forward.
                ex_ctrl_q <= dec_ctrl;
                ex_rd_q   <= dec_ctrl.reg_write ? id_rd  : '0;
                ex_rs1_q  <= dec_rs1            ? id_rs1 : '0;
                ex_rs2_q  <= dec_rs2            ? id_rs2 : '0;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        if (mem_rw_q && mem_rd_q != '0 && mem_rd_q == rs)
            return FWD_MEM;
        else if (wb_rw_q && wb_rd_q != '0 && wb_rd_q == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if (FWD_EN) begin
            fwd_a_c = fwd_sel(ex_rs1_q);
            fwd_b_c = fwd_sel(ex_rs2_q);
        end
    end

    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.ex_rs1         = ex_rs1_q;
    assign bus.ex_rs2         = ex_rs2_q;
    assign bus.mem_reg_write  = mem_rw_q;
    assign bus.mem_mem_read   = mem_mrd_q;
    assign bus.mem_mem_write  = mem_mwr_q;
    assign bus.mem_result_src = mem_res_q;
    assign bus.mem_rd         = mem_rd_q;
    assign bus.wb_reg_write   = wb_rw_q;
    assign bus.wb_result_src  = wb_res_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.fwd_a          = fwd_a_c;
    assign bus.fwd_b          = fwd_b_c;
    assign bus.illegal        = illegal_q;
endmodule
